// File: rtl/mux_nto1_pipe.sv
// N-input, WIDTH-bit registered selector with valid/ready handshake and a 2-entry skid buffer.
// Optional feature: define MUX_PARITY_EN to add the out_parity port and its storage.
module mux_nto1_pipe #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] din,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   muxout,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic               out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_err;
    logic             w_accept;
    logic             w_xfer;
    logic             w_load_out_in;
    logic             w_load_out_skid;
    logic             w_load_skid;

    logic [WIDTH-1:0] r_muxout;
    logic             r_out_err;
    logic [WIDTH-1:0] r_skid_word;
    logic             r_skid_err;

    // Word and error flag are decided together from the same sel sample.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_word = '0;
        w_sel_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_word = din[k*WIDTH +: WIDTH];
                w_sel_err  = 1'b0;
            end
        end
    end

    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = out_valid & out_ready;
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);

    // NOTE: state is a flop, so it uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_out_in = 1'b1;
                    w_next_state  = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_xfer) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = FULL;
                end else if (w_xfer) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_load_out_skid = 1'b1;
                    w_next_state    = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // NOTE: the skid entry is reset too, so a discarded word can never resurface.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_muxout    <= '0;
            r_out_err   <= 1'b0;
            r_skid_word <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_load_out_in) begin
                r_muxout  <= w_sel_word;
                r_out_err <= w_sel_err;
            end else if (w_load_out_skid) begin
                r_muxout  <= r_skid_word;
                r_out_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_word <= w_sel_word;
                r_skid_err  <= w_sel_err;
            end
        end
    end

    assign muxout  = r_muxout;
    assign out_err = r_out_err;

`ifdef MUX_PARITY_EN
    logic w_sel_parity;
    logic r_out_parity;
    logic r_skid_parity;

    assign w_sel_parity = ^w_sel_word;

    // Parity travels with its word through the same load paths as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_parity  <= 1'b0;
            r_skid_parity <= 1'b0;
        end else begin
            if (w_load_out_in) begin
                r_out_parity <= w_sel_parity;
            end else if (w_load_out_skid) begin
                r_out_parity <= r_skid_parity;
            end
            if (w_load_skid) begin
                r_skid_parity <= w_sel_parity;
            end
        end
    end

    assign out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: N=4 instance with a handshake scoreboard, plus an N=3 instance
// for the out-of-range select path. Parity checks are compiled in when MUX_PARITY_EN is defined.
module tb_mux_nto1_pipe;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        sel;
    logic [4*WIDTH-1:0] din;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  muxout;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;

    logic [1:0]        sel3;
    logic              in_valid3;
    logic              in_ready3;
    logic [WIDTH-1:0]  muxout3;
    logic              out_err3;
    logic              out_valid3;
    logic              out_ready3;

`ifdef MUX_PARITY_EN
    logic out_parity;
    logic out_parity3;
`endif

    logic [WIDTH-1:0] ch [4] = '{32'd21, 32'd3, 32'hDEADBEEF, 32'd7};

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_q[$];

    mux_nto1_pipe #(.N(4), .WIDTH(WIDTH), .SELW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .muxout    (muxout),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    mux_nto1_pipe #(.N(3), .WIDTH(WIDTH), .SELW(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel3),
        .din       (din[3*WIDTH-1:0]),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .muxout    (muxout3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(out_parity3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference selection for the N=4 instance: {err, word}.
    function automatic logic [32:0] model4(input logic [1:0] s);
        return {1'b0, ch[s]};
    endfunction

    // One clock: score the handshakes that complete on the coming edge, then step past it.
    task automatic tick();
        logic [32:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_word", {31'b0, out_err, muxout}, {31'b0, e});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model4(sel));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        din        = {ch[3], ch[2], ch[1], ch[0]};
        rst        = 1'b1;
        sel        = 2'd0;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;

        // Reset held three cycles with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_muxout", 64'(muxout), 64'd0);
            check("rst_out_err", 64'(out_err), 64'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic select, one word per cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd0;
        tick();
        check("basic_v0", 64'(out_valid), 64'd1);
        check("basic_d0", 64'(muxout), 64'd21);
        sel = 2'd1;
        tick();
        check("basic_d1", 64'(muxout), 64'd3);
        check("basic_e1", 64'(out_err), 64'd0);
        in_valid = 1'b0;
        tick();
        check("basic_drained", 64'(out_valid), 64'd0);

        // Backpressure: fill to FULL, third offer must be refused until space frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd2;
        tick();
        check("bp_d2", 64'(muxout), 64'hDEADBEEF);
        sel = 2'd3;
        tick();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_hold1", 64'(muxout), 64'hDEADBEEF);
        sel = 2'd0;
        tick();
        check("bp_refused_ready", 64'(in_ready), 64'd0);
        check("bp_hold2", 64'(muxout), 64'hDEADBEEF);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_drain7", 64'(muxout), 64'd7);
        tick();
        check("bp_drain21", 64'(muxout), 64'd21);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Out-of-range select on the N=3 instance.
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        sel3       = 2'd3;
        tick();
        check("oor_word", 64'(muxout3), 64'd0);
        check("oor_err", 64'(out_err3), 64'd1);
        check("oor_valid", 64'(out_valid3), 64'd1);
        sel3 = 2'd2;
        tick();
        check("oor_next_word", 64'(muxout3), 64'hDEADBEEF);
        check("oor_next_err", 64'(out_err3), 64'd0);
        in_valid3 = 1'b0;
        tick();

        // Mid-operation reset with both entries occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        tick();
        sel = 2'd2;
        tick();
        check("mr_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_muxout", 64'(muxout), 64'd0);
        out_ready = 1'b1;
        tick();
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_no_ghost", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        sel      = 2'd3;
        tick();
        check("mr_fresh", 64'(muxout), 64'd7);
        in_valid = 1'b0;
        tick();

`ifdef MUX_PARITY_EN
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd0;
        tick();
        check("par_21", 64'(out_parity), 64'd1);
        sel = 2'd1;
        tick();
        check("par_3", 64'(out_parity), 64'd0);
        in_valid = 1'b0;
        tick();
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
